// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_pkg
//  Purpose  : Shared types and constants for the forwarding / hazard unit.
//             The table entry carries fixed maximum-width address and latency
//             fields. Instantiations with narrower parameters zero-extend
//             their values into these fields, so comparisons stay exact.
//  Revision : 1.0 - initial release
// ============================================================================
package fwd_pkg;

  // Upper bounds for REG_AW and LAT_W accepted by fwd_hazard_unit
  localparam int FWD_AW_MAX    = 8;
  localparam int FWD_LAT_MAX_W = 4;

  // Forward select encodings (stage j result register = j)
  localparam int SEL_RF    = 0;
  localparam int SEL_EXMEM = 1;
  localparam int SEL_MEMWB = 2;

  // Result latencies: stages after EX until the value is forwardable
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  typedef struct packed {
    logic                     v;
    logic [FWD_AW_MAX-1:0]    addr;
    logic [FWD_LAT_MAX_W-1:0] rem;
  } fwd_entry_t;

  // Remaining-latency countdown, saturating at zero
  function automatic logic [FWD_LAT_MAX_W-1:0] rem_dec(
    input logic [FWD_LAT_MAX_W-1:0] rem
  );
    return (rem == '0) ? '0 : rem - FWD_LAT_MAX_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_unit_port_match.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_port_match
//  Purpose  : Priority search of the in-flight write table for one read port.
//             The youngest matching writer (smallest index) decides the
//             outcome: forward from its stage, use the register file, or
//             flag a hazard because its result is not ready yet.
//  Ports    : i_req    - port reads a register in a valid ID instruction
//             i_addr   - zero-extended source register address
//             i_tbl    - write table, index 0 = EX
//             o_sel    - next forward select (0 = register file)
//             o_hazard - result not ready, ID must stall
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic                  i_req,
  input  logic [FWD_AW_MAX-1:0] i_addr,
  input  fwd_entry_t            i_tbl [DEPTH],
  output logic [SEL_W-1:0]      o_sel,
  output logic                  o_hazard
);

  logic w_found;

  always_comb begin
    o_sel    = '0;
    o_hazard = 1'b0;
    w_found  = 1'b0;
    // Register 0 is hard-wired, so it is never forwarded or waited on
    if (i_req && (i_addr != '0)) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!w_found && i_tbl[k].v && (i_tbl[k].addr == i_addr)) begin
          w_found = 1'b1;
          // The last stage commits this cycle; the write-through register
          // file already returns its value, so no forward is needed.
          if (k != DEPTH - 1) begin
            if (i_tbl[k].rem <= FWD_LAT_MAX_W'(1)) begin
              o_sel = SEL_W'(k + 1);
            end else begin
              o_hazard = 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_unit
//  Purpose  : Forwarding and load-use hazard unit for a DEPTH-stage pipeline
//             tail (EX .. WB) with NUM_RD read ports per instruction and a
//             per-instruction result latency.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             id_valid        - valid instruction in ID
//             id_rd_addr      - source addresses, port i at [i*REG_AW +: REG_AW]
//             id_rd_used      - port i really reads a register
//             id_wr_en/addr   - destination write of the ID instruction
//             id_wr_lat       - result latency after EX (0 treated as 1)
//             flush           - kill the ID instruction
//             stall           - combinational: hold IF/ID, bubble into EX
//             ex_valid        - registered: EX instruction is real
//             ex_fwd_sel      - registered per-port forward selects
//  Options  : FWD_HAZARD_PERF_EN adds perf_stall_cnt and perf_fwd_cnt
//             (32-bit wrapping counters of stall cycles and active forwards)
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3,
  parameter int LAT_W  = 2,
  parameter int SEL_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NUM_RD*REG_AW-1:0] id_rd_addr,
  input  logic [NUM_RD-1:0]        id_rd_used,
  input  logic                     id_wr_en,
  input  logic [REG_AW-1:0]        id_wr_addr,
  input  logic [LAT_W-1:0]         id_wr_lat,
  input  logic                     flush,
  output logic                     stall,
  output logic                     ex_valid,
  output logic [NUM_RD*SEL_W-1:0]  ex_fwd_sel
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_fwd_cnt
`endif
);

  fwd_entry_t               r_tbl [DEPTH];
  fwd_entry_t               w_new;
  logic [FWD_AW_MAX-1:0]    w_rd_addr [NUM_RD];
  logic [SEL_W-1:0]         w_sel     [NUM_RD];
  logic [NUM_RD-1:0]        w_hazard;
  logic [NUM_RD*SEL_W-1:0]  w_sel_flat;
  logic                     w_ex_valid_nxt;

  // Zero-extend each source address into the table's address width
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_addr[i]             = '0;
      w_rd_addr[i][REG_AW-1:0] = id_rd_addr[i*REG_AW +: REG_AW];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_port
      fwd_port_match #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
      ) u_match (
        .i_req    (id_valid & id_rd_used[gi]),
        .i_addr   (w_rd_addr[gi]),
        .i_tbl    (r_tbl),
        .o_sel    (w_sel[gi]),
        .o_hazard (w_hazard[gi])
      );
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      w_sel_flat[i*SEL_W +: SEL_W] = w_sel[i];
    end
  end

  // A flushed instruction never waits, it is discarded anyway
  assign stall          = (|w_hazard) & ~flush;
  assign w_ex_valid_nxt = id_valid & ~stall & ~flush;

  // New EX entry; a latency of 0 is promoted to 1
  always_comb begin
    w_new                  = '0;
    w_new.v                = w_ex_valid_nxt & id_wr_en;
    w_new.addr[REG_AW-1:0] = id_wr_addr;
    w_new.rem[LAT_W-1:0]   = id_wr_lat;
    if (w_new.rem == '0) begin
      w_new.rem = FWD_LAT_MAX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_tbl[k] <= '0;
      end
      ex_valid   <= 1'b0;
      ex_fwd_sel <= '0;
    end else begin
      r_tbl[0] <= w_new;
      for (int k = 1; k < DEPTH; k++) begin
        r_tbl[k].v    <= r_tbl[k-1].v;
        r_tbl[k].addr <= r_tbl[k-1].addr;
        r_tbl[k].rem  <= rem_dec(r_tbl[k-1].rem);
      end
      ex_valid   <= w_ex_valid_nxt;
      ex_fwd_sel <= w_ex_valid_nxt ? w_sel_flat : '0;
    end
  end

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] w_fwd_nz;

  always_comb begin
    w_fwd_nz = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (ex_fwd_sel[i*SEL_W +: SEL_W] != '0) begin
        w_fwd_nz = w_fwd_nz + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {31'd0, stall};
      perf_fwd_cnt   <= perf_fwd_cnt + w_fwd_nz;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwd_hazard_unit
//  Purpose  : Directed self-checking bench for fwd_hazard_unit (default
//             parameters). Inputs change 1 time unit after the rising edge;
//             stall is read before the next edge, registered outputs 1 time
//             unit after it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

  localparam int REG_AW = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 3;
  localparam int LAT_W  = 2;
  localparam int SEL_W  = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     id_valid;
  logic [NUM_RD*REG_AW-1:0] id_rd_addr;
  logic [NUM_RD-1:0]        id_rd_used;
  logic                     id_wr_en;
  logic [REG_AW-1:0]        id_wr_addr;
  logic [LAT_W-1:0]         id_wr_lat;
  logic                     flush;
  logic                     stall;
  logic                     ex_valid;
  logic [NUM_RD*SEL_W-1:0]  ex_fwd_sel;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0]              perf_stall_cnt;
  logic [31:0]              perf_fwd_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .REG_AW (REG_AW),
    .NUM_RD (NUM_RD),
    .DEPTH  (DEPTH),
    .LAT_W  (LAT_W),
    .SEL_W  (SEL_W)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rd_addr (id_rd_addr),
    .id_rd_used (id_rd_used),
    .id_wr_en   (id_wr_en),
    .id_wr_addr (id_wr_addr),
    .id_wr_lat  (id_wr_lat),
    .flush      (flush),
    .stall      (stall),
    .ex_valid   (ex_valid),
    .ex_fwd_sel (ex_fwd_sel)
`ifdef FWD_HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one ID instruction (valid, writer fields, two read ports, flush)
  task automatic issue(input logic v, input logic we, input int wa,
                       input int lat, input int ra0, input logic u0,
                       input int ra1, input logic u1, input logic fl);
    id_valid   = v;
    id_wr_en   = we;
    id_wr_addr = REG_AW'(wa);
    id_wr_lat  = LAT_W'(lat);
    id_rd_addr = {REG_AW'(ra1), REG_AW'(ra0)};
    id_rd_used = {u1, u0};
    flush      = fl;
    #1;
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    check_eq("reset ex_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("reset sel", {28'd0, ex_fwd_sel}, 32'd0);
    check_eq("reset stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    #1;

    // ALU back-to-back: add r3 then sub r3 on port 0 -> EX/MEM forward
    issue(1'b1, 1'b1, 3, 1, 1, 1'b1, 2, 1'b1, 1'b0);
    check_eq("alu writer stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("alu writer ex_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("alu writer sel", {28'd0, ex_fwd_sel}, 32'd0);
    issue(1'b1, 1'b0, 0, 1, 3, 1'b1, 6, 1'b1, 1'b0);
    check_eq("alu reader stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("alu reader ex_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("alu reader sel", {28'd0, ex_fwd_sel}, 32'h1);

    // Load-use: lw r5 then reader of r5 on port 1 -> one stall, then MEM/WB
    issue(1'b1, 1'b1, 5, 2, 1, 1'b1, 0, 1'b0, 1'b0);
    check_eq("load stall", {31'd0, stall}, 32'd0);
    tick();
    issue(1'b1, 1'b1, 10, 1, 9, 1'b1, 5, 1'b1, 1'b0);
    check_eq("load-use stall", {31'd0, stall}, 32'd1);
    tick();
    check_eq("load-use bubble ex_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("load-use bubble sel", {28'd0, ex_fwd_sel}, 32'd0);
    check_eq("load-use stall released", {31'd0, stall}, 32'd0);
    tick();
    check_eq("load-use ex_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("load-use sel", {28'd0, ex_fwd_sel}, 32'h8);

    // Double writer: the younger r4 wins on both ports
    issue(1'b1, 1'b1, 4, 1, 0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    issue(1'b1, 1'b1, 4, 1, 0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    issue(1'b1, 1'b0, 0, 1, 4, 1'b1, 4, 1'b1, 1'b0);
    check_eq("double writer stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("double writer sel", {28'd0, ex_fwd_sel}, 32'h5);

    // Distance DEPTH: writer r7 has reached WB, read via write-through
    issue(1'b1, 1'b1, 7, 1, 0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    issue(1'b1, 1'b0, 0, 1, 0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    tick();
    issue(1'b1, 1'b0, 0, 1, 7, 1'b1, 0, 1'b0, 1'b0);
    check_eq("depth stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("depth ex_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("depth sel", {28'd0, ex_fwd_sel}, 32'd0);

    // Register 0: lw r0 then reader of r0 on both ports
    issue(1'b1, 1'b1, 0, 2, 0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    issue(1'b1, 1'b0, 0, 1, 0, 1'b1, 0, 1'b1, 1'b0);
    check_eq("r0 stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("r0 ex_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("r0 sel", {28'd0, ex_fwd_sel}, 32'd0);

    // Load-use with flush: no stall, bubble enters EX
    issue(1'b1, 1'b1, 11, 2, 0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    issue(1'b1, 1'b0, 0, 1, 11, 1'b1, 0, 1'b0, 1'b1);
    check_eq("flush stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("flush ex_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("flush sel", {28'd0, ex_fwd_sel}, 32'd0);

    // Latency 0 behaves like an ALU result
    issue(1'b1, 1'b1, 12, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    issue(1'b1, 1'b0, 0, 1, 0, 1'b0, 12, 1'b1, 1'b0);
    check_eq("lat0 stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("lat0 sel", {28'd0, ex_fwd_sel}, 32'h4);

    // Reset in the middle of a load-use stall
    issue(1'b1, 1'b1, 13, 2, 0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    issue(1'b1, 1'b0, 0, 1, 13, 1'b1, 0, 1'b0, 1'b0);
    check_eq("pre-reset stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("post-reset stall", {31'd0, stall}, 32'd0);
    check_eq("post-reset ex_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("post-reset sel", {28'd0, ex_fwd_sel}, 32'd0);
    tick();
    check_eq("post-reset reader ex_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("post-reset reader sel", {28'd0, ex_fwd_sel}, 32'd0);

    idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
